// File: rtl/ram_port_arbiter.sv
// Clears the external single-port RAM after reset, then shares its one port
// between two requesters with a round-robin req/grant handshake.
module ram_port_arbiter #(
    parameter int              AW         = 3,
    parameter int              DW         = 4,
    parameter bit              INIT_CLEAR = 1'b1,
    parameter logic [DW-1:0]   INIT_VALUE = '0
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_req0,
    input  logic          i_req1,
    input  logic          i_wr0,
    input  logic          i_wr1,
    input  logic [AW-1:0] i_addr0,
    input  logic [AW-1:0] i_addr1,
    input  logic [DW-1:0] i_wdata0,
    input  logic [DW-1:0] i_wdata1,
    output logic          o_gnt0,
    output logic          o_gnt1,
    output logic          o_rvalid0,
    output logic          o_rvalid1,
    output logic [DW-1:0] o_rdata,
    output logic          o_ready,
    output logic [AW-1:0] o_ram_addr,
    output logic [DW-1:0] o_ram_din,
    output logic          o_ram_we,
    input  logic [DW-1:0] i_ram_dout
);

    localparam int            DEPTH    = 2 ** AW;
    localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SERVE = 2'd2
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_cnt;
    logic          r_prio;
    logic          r_ready;
    logic [1:0]    r_rvalid;

    logic          w_serve;
    logic [1:0]    w_req;
    logic [1:0]    w_wr;
    logic [1:0]    w_gnt;
    logic [AW-1:0] w_addr  [2];
    logic [DW-1:0] w_wdata [2];

    assign w_req      = {i_req1, i_req0};
    assign w_wr       = {i_wr1, i_wr0};
    assign w_addr[0]  = i_addr0;
    assign w_addr[1]  = i_addr1;
    assign w_wdata[0] = i_wdata0;
    assign w_wdata[1] = i_wdata1;

    // Grants open only once READY is visible, so requesters never see a
    // grant before the cycle in which READY first reads 1.
    assign w_serve = (r_state == ST_SERVE) && r_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign w_gnt[gi] = w_serve & w_req[gi]
                             & (~w_req[1-gi] | (r_prio == 1'(gi)));
        end
    endgenerate

    always_comb begin
        o_ram_addr = '0;
        o_ram_din  = '0;
        o_ram_we   = 1'b0;
        if (r_state == ST_CLEAR) begin
            o_ram_addr = r_cnt;
            o_ram_din  = INIT_VALUE;
            o_ram_we   = 1'b1;
        end else if (w_gnt[0]) begin
            o_ram_addr = w_addr[0];
            o_ram_din  = w_wdata[0];
            o_ram_we   = w_wr[0];
        end else if (w_gnt[1]) begin
            o_ram_addr = w_addr[1];
            o_ram_din  = w_wdata[1];
            o_ram_we   = w_wr[1];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_START;
            r_cnt    <= '0;
            r_prio   <= 1'b0;
            r_ready  <= 1'b0;
            r_rvalid <= 2'b00;
        end else begin
            r_ready  <= (r_state == ST_SERVE);
            r_rvalid <= w_gnt & ~w_wr;
            case (r_state)
                ST_START: r_state <= INIT_CLEAR ? ST_CLEAR : ST_SERVE;
                ST_CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    if (w_gnt[0]) begin
                        r_prio <= 1'b1;
                    end else if (w_gnt[1]) begin
                        r_prio <= 1'b0;
                    end
                end
                default: r_state <= ST_START;
            endcase
        end
    end

    assign o_gnt0    = w_gnt[0];
    assign o_gnt1    = w_gnt[1];
    assign o_rvalid0 = r_rvalid[0];
    assign o_rvalid1 = r_rvalid[1];
    assign o_ready   = r_ready;
    assign o_rdata   = i_ram_dout;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios followed by a randomized run,
// all checked against a cycle-count / array reference model of the rules.
module tb_ram_port_arbiter;

    localparam int          AW    = 3;
    localparam int          DW    = 4;
    localparam int          DEPTH = 8;
    localparam logic [3:0]  IV    = 4'hA;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, req1, wr0, wr1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, ready, ram_we;
    logic [DW-1:0] rdata, ram_din, ram_dout;
    logic [AW-1:0] ram_addr;

    logic [DW-1:0] mem [DEPTH];

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int            cyc;
    bit            prio;
    bit            exp_rv0, exp_rv1;
    logic [DW-1:0] exp_rdata;
    logic [DW-1:0] ref_mem [DEPTH];
    bit            last_g0, last_g1;

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .AW(AW), .DW(DW), .INIT_CLEAR(1'b1), .INIT_VALUE(IV)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0(req0), .i_req1(req1), .i_wr0(wr0), .i_wr1(wr1),
        .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_gnt0(gnt0), .o_gnt1(gnt1), .o_rvalid0(rvalid0), .o_rvalid1(rvalid1),
        .o_rdata(rdata), .o_ready(ready),
        .o_ram_addr(ram_addr), .o_ram_din(ram_din), .o_ram_we(ram_we),
        .i_ram_dout(ram_dout)
    );

    // Single-port RAM with registered read of the address sampled on the edge
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 4'h3;
    end
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input int a0, input int d0,
                         input logic r1, input logic w1, input int a1, input int d1);
        req0 = r0; wr0 = w0; addr0 = AW'(a0); wdata0 = DW'(d0);
        req1 = r1; wr1 = w1; addr1 = AW'(a1); wdata1 = DW'(d1);
    endtask

    // One clock cycle: predict, check outputs, advance the model on the edge.
    task automatic step();
        bit            eg0, eg1, ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        eg0 = 0; eg1 = 0; ewe = 0; ea = '0; ed = '0;
        if (cyc >= 1 && cyc <= DEPTH) begin
            ewe = 1; ea = AW'(cyc - 1); ed = IV;
        end else if (cyc >= DEPTH + 2) begin
            if (req0 && req1) begin
                eg0 = (prio == 0); eg1 = !eg0;
            end else begin
                eg0 = req0; eg1 = req1;
            end
            if (eg0) begin
                ewe = wr0; ea = addr0; ed = wdata0;
            end else if (eg1) begin
                ewe = wr1; ea = addr1; ed = wdata1;
            end
        end
        #1;
        chk("gnt0",     8'(gnt0),     8'(eg0));
        chk("gnt1",     8'(gnt1),     8'(eg1));
        chk("ram_we",   8'(ram_we),   8'(ewe));
        chk("ram_addr", 8'(ram_addr), 8'(ea));
        chk("ram_din",  8'(ram_din),  8'(ed));
        chk("ready",    8'(ready),    8'(cyc >= DEPTH + 2));
        chk("rvalid0",  8'(rvalid0),  8'(exp_rv0));
        chk("rvalid1",  8'(rvalid1),  8'(exp_rv1));
        if (exp_rv0 || exp_rv1) chk("rdata", 8'(rdata), 8'(exp_rdata));
        @(posedge clk);
        cyc++;
        exp_rv0 = eg0 && !wr0;
        exp_rv1 = eg1 && !wr1;
        if (exp_rv0 || exp_rv1) exp_rdata = ref_mem[ea];
        if (ewe) ref_mem[ea] = ed;
        if (eg0) prio = 1;
        else if (eg1) prio = 0;
        last_g0 = eg0; last_g1 = eg1;
        @(negedge clk);
    endtask

    // Assert reset (possibly mid-cycle), check async reset values, release on a negedge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, "_gnt0"},    8'(gnt0),     8'h00);
        chk({tag, "_gnt1"},    8'(gnt1),     8'h00);
        chk({tag, "_rvalid0"}, 8'(rvalid0),  8'h00);
        chk({tag, "_rvalid1"}, 8'(rvalid1),  8'h00);
        chk({tag, "_ready"},   8'(ready),    8'h00);
        chk({tag, "_we"},      8'(ram_we),   8'h00);
        chk({tag, "_addr"},    8'(ram_addr), 8'h00);
        chk({tag, "_din"},     8'(ram_din),  8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc = 0; prio = 0; exp_rv0 = 0; exp_rv1 = 0; last_g0 = 0; last_g1 = 0;
    endtask

    initial begin
        rst_n = 1'b1;
        exp_rdata = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 4'h3;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        #3;
        do_reset("rst");

        // Clear interrupted at CNT = 4, with requester 0 holding a read
        while (cyc < 5) step();
        #2;
        chk("midclear_we",   8'(ram_we),   8'h01);
        chk("midclear_addr", 8'(ram_addr), 8'(cyc - 1));
        do_reset("midrst");

        // Full clear; GNT0 must first appear together with READY
        repeat (DEPTH + 3) step();

        // Every location reads back the clear value
        for (int a = 0; a < DEPTH; a++) begin
            drive(1, 0, a, 0, 0, 0, 0, 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();

        // Single requester: write then read address 3
        drive(1, 1, 3, 5, 0, 0, 0, 0); step();
        drive(1, 0, 3, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0); step();

        // Contention: both reading continuously
        drive(1, 0, 1, 0, 1, 0, 2, 0);
        repeat (6) step();
        drive(0, 0, 0, 0, 0, 0, 0, 0); step();

        // Withdrawal: requester 1 pulses while requester 0 holds the grant
        drive(0, 0, 0, 0, 1, 0, 6, 0); step();
        drive(1, 0, 5, 0, 1, 0, 6, 0); step();
        drive(1, 0, 5, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0); step();

        // Read-after-write across requesters, then reset while RVALID is pending
        drive(0, 0, 0, 0, 1, 1, 7, 12); step();
        drive(1, 0, 7, 0, 0, 0, 0, 0);  step();
        chk("raw_rvalid0", 8'(rvalid0), 8'(exp_rv0));
        chk("raw_rdata",   8'(rdata),   8'(exp_rdata));
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        do_reset("pendrst");

        // Randomized traffic obeying the hold-until-grant handshake
        repeat (DEPTH + 2) step();
        for (int n = 0; n < 400; n++) begin
            if (!req0 || last_g0) begin
                req0 = ($urandom_range(0, 3) != 0); wr0 = 1'($urandom);
                addr0 = AW'($urandom); wdata0 = DW'($urandom);
            end else if ($urandom_range(0, 7) == 0) begin
                req0 = 1'b0;
            end
            if (!req1 || last_g1) begin
                req1 = ($urandom_range(0, 3) != 0); wr1 = 1'($urandom);
                addr1 = AW'($urandom); wdata1 = DW'($urandom);
            end else if ($urandom_range(0, 7) == 0) begin
                req1 = 1'b0;
            end
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
